shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Command sequencer for the 16-bit registered shifter (shift codes 0–4; any other code holds the register).
- Accepts one command: operand, operation, shift amount and fill bit. Loads the operand into the shifter, issues the shift code once per cycle for the requested amount, then captures the result and the carry-out.
- Sits between a requesting unit and the shifter and is the only driver of the shifter's shift, cin and indata inputs.

Parameters:
- WIDTH, 16, datapath width; must match the shifter.
- CNT_W, 5, width of the amount field.
- HOLD_CODE, 3'd7, shift code driven when the shifter must hold its value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  command request, sampled on the rising edge.
- op  input  2  operation: 0 rotate left, 1 shift left with fill, 2 rotate right, 3 shift right with fill.
- amount  input  CNT_W  number of 1-bit shifts; values above WIDTH saturate to WIDTH.
- fill  input  1  bit inserted by ops 1 and 3.
- load_data  input  WIDTH  operand.
- busy  output  1  high while a command is executing.
- done  output  1  one-cycle pulse; result and carry are valid in that cycle.
- result  output  WIDTH  captured shifter output; held until the next done.
- carry  output  1  last bit shifted out; 0 when amount is 0.
- sh_shift  output  3  shift code to the shifter.
- sh_cin  output  1  shifter cin; equals the latched fill.
- sh_indata  output  WIDTH  shifter parallel-load data.
- sh_outdata  input  WIDTH  shifter register output.
- sh_cout  input  1  shifter carry output.

Behaviour:
- Reset values: state IDLE, busy 0, done 0, result 0, carry 0, sh_shift HOLD_CODE, sh_cin 0, sh_indata 0, remaining-count 0. The shifter has no reset; its contents are don't-care until the next LOAD.
- States: IDLE, LOAD, SHIFT, CAPT, DONE.
- IDLE or DONE, start=1: latch op, fill, load_data and amount (saturated to WIDTH) into the remaining-count; go to LOAD. Back-to-back commands are allowed from DONE.
- LOAD (one cycle): sh_shift=3'd4, sh_indata=latched data. Next state is SHIFT if the count is nonzero, otherwise CAPT.
- SHIFT: sh_shift={1'b0,op}, sh_cin=fill. Decrement the count every cycle. When the count reaches 1, the next state is CAPT. Exactly `amount` shift edges are issued.
- CAPT: sh_shift=HOLD_CODE. On the exiting edge, register result<=sh_outdata and carry<=sh_cout; go to DONE.
  - For amount 0, sh_cout reflects the load, so carry is 0.
- DONE: done=1 for one cycle, busy=0. Go to IDLE unless start=1.
- busy is 1 in LOAD, SHIFT and CAPT; 0 in IDLE and DONE.
- start while busy=1: ignored with no side effects; the latched command is unchanged.
- Latency: start accepted at edge T → done high in cycle T+3+N, where N is the saturated amount (T+3 for amount 0).
- sh_shift is HOLD_CODE in IDLE, CAPT and DONE. The shifter value is never altered outside LOAD and SHIFT.
- rst mid-command: next cycle is in reset state; no done pulse; the shifter is left holding its partial value; a new command then works normally.
- Amount saturation: rotate by WIDTH returns the operand. Shift by WIDTH returns all-fill.

Test Plan:
- Rotate left: op=0, data 16'h8001, amount=1, start at T → done at T+4, result 16'h0003, carry 1.
- Shift right with fill: op=3, fill=1, data 16'h00F0, amount=4 → result 16'hF00F, carry 0, done at T+7.
- Rotate right: op=2, data 16'hA5C3, amount=16 → result 16'hA5C3, carry 1. Repeat with amount=20 → identical result and timing (saturation).
- Zero amount: op=1, data 16'h1234, amount=0 → result 16'h1234, carry 0, done at T+3, no shift code 1 issued.
- Shift left with fill: op=1, fill=1, data 16'h4000, amount=2 → result 16'h0003, carry 1. A second start issued during DONE executes back-to-back.
- Robustness: start pulsed during SHIFT → ignored. rst asserted mid-SHIFT → busy 0, sh_shift 7, no done. Then a new command (op=0, 16'h8001, amount=1) → 16'h0003, carry 1.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: loads an operand into a registered shifter, issues N shift codes, then captures result and carry.
module shift_seq_ctrl #(
   parameter int         WIDTH     = 16,
   parameter int         CNT_W     = 5,
   parameter logic [2:0] HOLD_CODE = 3'd7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [CNT_W-1:0] amount,
   input  logic             fill,
   input  logic [WIDTH-1:0] load_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic [2:0]       sh_shift,
   output logic             sh_cin,
   output logic [WIDTH-1:0] sh_indata,
   input  logic [WIDTH-1:0] sh_outdata,
   input  logic             sh_cout
);
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPT, DONE} state_t;
   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             fill_q, fill_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      fill_d   = fill_q;
      data_d   = data_q;
      result_d = result_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      accept   = start && (state_q == IDLE || state_q == DONE);
      if (accept) begin
         op_d    = op;
         fill_d  = fill;
         data_d  = load_data;
         cnt_d   = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;
         state_d = LOAD;
      end else begin
         case (state_q)
            LOAD:  state_d = (cnt_q != '0) ? SHIFT : CAPT;
            SHIFT: begin
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_q == CNT_W'(1)) ? CAPT : SHIFT;
            end
            CAPT: begin
               result_d = sh_outdata;
               carry_d  = sh_cout;
               state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         fill_q   <= 1'b0;
         data_q   <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         fill_q   <= fill_d;
         data_q   <= data_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
      end
   end
   // The shifter is only ever told to change in LOAD and SHIFT; everywhere else it holds.
   assign sh_shift  = (state_q == LOAD) ? 3'd4 : (state_q == SHIFT) ? {1'b0, op_q} : HOLD_CODE;
   assign sh_cin    = fill_q;
   assign sh_indata = data_q;
   assign busy      = (state_q == LOAD) || (state_q == SHIFT) || (state_q == CAPT);
   assign done      = (state_q == DONE);
   assign result    = result_q;
   assign carry     = carry_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: drives shift_seq_ctrl against a behavioural shifter and an arithmetic reference model.
module tb_shift_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst, start, fill, busy, done, carry, sh_cin, sh_cout;
   logic [1:0]  op;
   logic [4:0]  amount;
   logic [15:0] load_data, result, sh_indata, sh_outdata, sh_reg;
   logic [2:0]  sh_shift;
   int          errors = 0;
   int          checks = 0;
   always #5 clk = ~clk;
   shift_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount), .fill(fill),
      .load_data(load_data), .busy(busy), .done(done), .result(result), .carry(carry),
      .sh_shift(sh_shift), .sh_cin(sh_cin), .sh_indata(sh_indata),
      .sh_outdata(sh_outdata), .sh_cout(sh_cout)
   );
   // Registered shifter with no reset; codes above 4 hold.
   always @(posedge clk) begin
      case (sh_shift)
         3'd0: begin sh_reg <= {sh_reg[14:0], sh_reg[15]}; sh_cout <= sh_reg[15]; end
         3'd1: begin sh_reg <= {sh_reg[14:0], sh_cin};     sh_cout <= sh_reg[15]; end
         3'd2: begin sh_reg <= {sh_reg[0], sh_reg[15:1]};  sh_cout <= sh_reg[0];  end
         3'd3: begin sh_reg <= {sh_cin, sh_reg[15:1]};     sh_cout <= sh_reg[0];  end
         3'd4: begin sh_reg <= sh_indata;                  sh_cout <= 1'b0;       end
         default: ;
      endcase
   end
   assign sh_outdata = sh_reg;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic void ref_model(input logic [1:0] o, input logic f, input logic [15:0] d,
                                     input int n, output logic [15:0] r, output logic c);
      int          ns = (n > 16) ? 16 : n;
      logic [31:0] dd = {16'h0, d};
      logic [15:0] ones = 16'hFFFF;
      logic [31:0] fl = f ? ((32'h1 << ns) - 32'h1) : 32'h0;
      if (ns == 0) begin
         r = d;
         c = 1'b0;
      end else begin
         case (o)
            2'd0: begin r = 16'((dd << ns) | (dd >> (16 - ns))); c = d[16-ns]; end
            2'd1: begin r = 16'((dd << ns) | fl);                c = d[16-ns]; end
            2'd2: begin r = 16'((dd >> ns) | (dd << (16 - ns))); c = d[ns-1];  end
            default: begin r = 16'(dd >> ns) | (f ? ~(ones >> ns) : 16'h0); c = d[ns-1]; end
         endcase
      end
   endfunction
   task automatic issue(input logic [1:0] o, input logic f, input logic [15:0] d, input logic [4:0] a);
      op = o; fill = f; load_data = d; amount = a; start = 1'b1;
   endtask
   // Counts cycles from acceptance (cycle 1 = LOAD) until done; optionally pokes a stray start at cycle poke.
   task automatic wait_done(input string tag, input logic [15:0] er, input logic ec, input int n, input int poke);
      int c = 0;
      int shifts = 0;
      int busy_cyc = 0;
      do begin
         @(posedge clk);
         c++;
         @(negedge clk);
         if (sh_shift < 3'd4) shifts++;
         if (busy) busy_cyc++;
         start = (c == poke);
         if (c == poke) begin op = 2'd3; fill = 1'b1; load_data = 16'hFFFF; amount = 5'd2; end
      end while (!done && c < 60);
      check({tag, "_latency"}, 32'(c), 32'(3 + n));
      check({tag, "_result"}, 32'(result), 32'(er));
      check({tag, "_carry"}, 32'(carry), 32'(ec));
      check({tag, "_shifts"}, 32'(shifts), 32'(n));
      check({tag, "_busy"}, 32'(busy_cyc), 32'(2 + n));
   endtask
   initial begin
      logic [15:0] er, held;
      logic        ec;
      int          n, seen;
      rst = 1'b1; start = 1'b0; op = '0; fill = 1'b0; amount = '0; load_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_shift", 32'(sh_shift), 32'd7);
      check("rst_cin", 32'(sh_cin), 32'd0);
      check("rst_indata", 32'(sh_indata), 32'd0);
      rst = 1'b0;
      issue(2'd0, 1'b0, 16'h8001, 5'd1);
      wait_done("rotl1", 16'h0003, 1'b1, 1, -1);
      @(posedge clk); @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("idle_shift", 32'(sh_shift), 32'd7);
      issue(2'd3, 1'b1, 16'h00F0, 5'd4);
      wait_done("shr_fill", 16'hF00F, 1'b0, 4, -1);
      @(posedge clk); @(negedge clk);
      issue(2'd2, 1'b0, 16'hA5C3, 5'd16);
      wait_done("rotr16", 16'hA5C3, 1'b1, 16, -1);
      @(posedge clk); @(negedge clk);
      issue(2'd2, 1'b0, 16'hA5C3, 5'd20);
      wait_done("rotr20", 16'hA5C3, 1'b1, 16, -1);
      @(posedge clk); @(negedge clk);
      issue(2'd1, 1'b0, 16'h1234, 5'd0);
      wait_done("zero_amt", 16'h1234, 1'b0, 0, -1);
      @(posedge clk); @(negedge clk);
      issue(2'd1, 1'b1, 16'h4000, 5'd2);
      wait_done("shl_fill", 16'h0003, 1'b1, 2, -1);
      issue(2'd0, 1'b0, 16'h8001, 5'd1);
      wait_done("b2b", 16'h0003, 1'b1, 1, -1);
      @(posedge clk); @(negedge clk);
      ref_model(2'd0, 1'b0, 16'h1234, 10, er, ec);
      issue(2'd0, 1'b0, 16'h1234, 5'd10);
      wait_done("ignored_start", er, ec, 10, 5);
      @(posedge clk); @(negedge clk);
      issue(2'd1, 1'b1, 16'h0FFF, 5'd12);
      repeat (4) begin @(posedge clk); @(negedge clk); start = 1'b0; end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      held = sh_outdata;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_shift", 32'(sh_shift), 32'd7);
      check("midrst_result", 32'(result), 32'd0);
      seen = 0;
      repeat (20) begin @(posedge clk); @(negedge clk); if (done) seen++; end
      check("midrst_nodone", 32'(seen), 32'd0);
      check("midrst_hold", 32'(sh_outdata), 32'(held));
      issue(2'd0, 1'b0, 16'h8001, 5'd1);
      wait_done("after_rst", 16'h0003, 1'b1, 1, -1);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); @(negedge clk);
         issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom), 5'($urandom_range(0, 31)));
         n = (int'(amount) > 16) ? 16 : int'(amount);
         ref_model(op, fill, load_data, int'(amount), er, ec);
         wait_done($sformatf("rand%0d", i), er, ec, n, -1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
